stream_injector: RTL
====================

Name: stream_injector

Overview:
- Master-side counterpart of the bus tap. Accepts AXI-Stream beats produced by the HLS kernel and drives them onto a downstream AXI-Stream bus with full TREADY/TVALID handshaking.
- Beats are buffered in a small FIFO.
- An enable gate starts and stops injection only on packet boundaries, so the downstream bus never sees a truncated packet.
- Beat and packet counters are exposed for the monitoring path.

Parameters:
- TDATA_WIDTH, 512, data width in bits.
- TKEEP_WIDTH, TDATA_WIDTH/8, byte-keep width.
- TDEST_WIDTH, 16, TDEST width.
- TID_WIDTH, 16, TID width.
- FIFO_DEPTH, 4, beat buffer depth; power of 2, minimum 2.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  injection gate, sampled every cycle.
- hls_TDATA  in  TDATA_WIDTH  beat data from the kernel.
- hls_TKEEP  in  TKEEP_WIDTH  byte keep.
- hls_TDEST  in  TDEST_WIDTH  destination.
- hls_TID  in  TID_WIDTH  stream ID.
- hls_TVALID  in  1  kernel beat valid.
- hls_TLAST  in  1  last beat of packet.
- hls_TREADY  out  1  high when the FIFO is not full.
- out_TDATA  out  TDATA_WIDTH  injected data.
- out_TKEEP  out  TKEEP_WIDTH  injected keep.
- out_TDEST  out  TDEST_WIDTH  injected dest.
- out_TID  out  TID_WIDTH  injected ID.
- out_TVALID  out  1  injected beat valid.
- out_TLAST  out  1  injected last.
- out_TREADY  in  1  downstream ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- beat_count  out  CNT_WIDTH  output transfers completed.
- pkt_count  out  CNT_WIDTH  output transfers with TLAST.
- busy  out  1  high when state is not IDLE or fifo_level is non-zero.

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high.
  - While rst=1: hls_TREADY=0, out_TVALID=0, FIFO emptied, fifo_level=0, counters=0, in_pkt=0, state=IDLE, busy=0.
  - FIFO storage is not reset.
  - out_TDATA, out_TKEEP, out_TDEST, out_TID and out_TLAST are don't-care while out_TVALID=0.
  - Asserting rst mid-packet discards all buffered beats; the partial packet is never completed.
- Input side:
  - Write occurs on hls_TVALID & hls_TREADY.
  - hls_TREADY = !rst & (fifo_level != FIFO_DEPTH).
  - No combinational path from out_TREADY to hls_TREADY. When full, a read in the same cycle does not enable a write until the next cycle.
- Latency: a beat written in cycle N can appear on out_* in cycle N+1 at the earliest.
- Output side:
  - out_TVALID = (FIFO not empty) & (state != IDLE). The only exception is the stall rule below.
  - A transfer occurs on out_TVALID & out_TREADY; it pops the FIFO head. out_* always present the FIFO head.
  - Stall rule: once out_TVALID=1 and out_TREADY=0, out_TVALID stays 1 and out_* stay stable until the transfer, regardless of enable or state.
- Simultaneous write and read: fifo_level is unchanged and both beats are handled. Pointers wrap modulo FIFO_DEPTH.
- in_pkt: set on an output transfer with TLAST=0; cleared on an output transfer with TLAST=1.
- State machine (IDLE, ACTIVE, STOPPING):
  - IDLE → ACTIVE when enable=1. The FIFO keeps filling while IDLE.
  - ACTIVE with enable=0:
    - no beat pending (out_TVALID=0 or a TLAST transfer this cycle) and in_pkt would be 0 next cycle → IDLE;
    - otherwise → STOPPING.
  - STOPPING → IDLE on an output transfer with TLAST=1.
  - STOPPING → ACTIVE if enable=1 first. If both happen in the same cycle, ACTIVE wins.
- Counters:
  - beat_count increments on each output transfer; pkt_count increments on each output transfer with TLAST=1.
  - Both wrap at 2^CNT_WIDTH and are cleared only by rst.

Test Plan:
- enable=1, out_TREADY=1, 3-beat packet (data 0x1,0x2,0x3, TLAST on 0x3) → out_* show the same beats in order, first beat one cycle after its write; beat_count=3, pkt_count=1.
- enable=0, push 5 beats with FIFO_DEPTH=4 → hls_TREADY drops after 4 writes, fifo_level=4, out_TVALID=0. Then enable=1 → 4 beats drain, the 5th is accepted the cycle after the first pop, fifo_level returns to 0.
- Drop enable after beat 1 of a 4-beat packet → beats 2-4 still emitted (STOPPING), then IDLE. The next queued packet is held with out_TVALID=0 and pkt_count=1.
- out_TVALID=1 with out_TREADY=0 for 3 cycles while enable drops → out_TVALID and out_TDATA are held constant until out_TREADY=1; exactly one transfer is counted.
- Full FIFO with simultaneous hls_TVALID=1 and out_TREADY=1 → only the read occurs that cycle; the write completes the following cycle; no beat is lost or duplicated.
- rst pulse mid-packet with 2 beats buffered → next cycle fifo_level=0, counters=0, out_TVALID=0, state IDLE, in_pkt=0.

Source files
------------

// File: rtl/stream_injector.sv
`default_nettype none
// ============================================================================
// Module   : stream_injector
// Brief    : FIFO-buffered AXI-Stream injector with a packet-boundary enable
//            gate and beat/packet statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module stream_injector #(
    parameter int TDATA_WIDTH = 512,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int TDEST_WIDTH = 16,
    parameter int TID_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [TDATA_WIDTH-1:0]        hls_TDATA,
    input  logic [TKEEP_WIDTH-1:0]        hls_TKEEP,
    input  logic [TDEST_WIDTH-1:0]        hls_TDEST,
    input  logic [TID_WIDTH-1:0]          hls_TID,
    input  logic                          hls_TVALID,
    input  logic                          hls_TLAST,
    output logic                          hls_TREADY,
    output logic [TDATA_WIDTH-1:0]        out_TDATA,
    output logic [TKEEP_WIDTH-1:0]        out_TKEEP,
    output logic [TDEST_WIDTH-1:0]        out_TDEST,
    output logic [TID_WIDTH-1:0]          out_TID,
    output logic                          out_TVALID,
    output logic                          out_TLAST,
    input  logic                          out_TREADY,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]          beat_count,
    output logic [CNT_WIDTH-1:0]          pkt_count,
    output logic                          busy
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_EW = TDATA_WIDTH + TKEEP_WIDTH + TDEST_WIDTH + TID_WIDTH + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_EW-1:0]    r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_LW-1:0]    r_level;
    logic               r_in_pkt;
    logic               r_hold;
    logic [CNT_WIDTH-1:0] r_beat_cnt;
    logic [CNT_WIDTH-1:0] r_pkt_cnt;

    logic               w_empty;
    logic               w_wr;
    logic               w_rd;
    logic               w_last_xfer;
    logic               w_in_pkt_nxt;
    logic [c_EW-1:0]    w_head;

    assign w_empty    = (r_level == '0);
    assign hls_TREADY = !rst && (r_level != c_FULL);
    assign w_wr       = hls_TVALID && hls_TREADY;

    // r_hold keeps a stalled beat presented even if the gate closes underneath it
    assign out_TVALID  = !rst && !w_empty && ((r_state != ST_IDLE) || r_hold);
    assign w_rd        = out_TVALID && out_TREADY;
    assign w_head      = r_mem[r_rd_ptr];
    assign {out_TDATA, out_TKEEP, out_TDEST, out_TID, out_TLAST} = w_head;
    assign w_last_xfer = w_rd && out_TLAST;
    assign w_in_pkt_nxt = w_rd ? !out_TLAST : r_in_pkt;

    assign fifo_level = r_level;
    assign beat_count = r_beat_cnt;
    assign pkt_count  = r_pkt_cnt;
    assign busy       = !rst && ((r_state != ST_IDLE) || !w_empty);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {hls_TDATA, hls_TKEEP, hls_TDEST, hls_TID, hls_TLAST};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_in_pkt   <= 1'b0;
            r_hold     <= 1'b0;
            r_beat_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_in_pkt <= w_in_pkt_nxt;
            r_hold   <= out_TVALID && !out_TREADY;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (w_last_xfer) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!enable) begin
                    if ((!out_TVALID || w_last_xfer) && !w_in_pkt_nxt) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_STOPPING;
                    end
                end
            end
            ST_STOPPING: begin
                if (enable) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_last_xfer) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire
